alu_serial_ctrl: RTL and testbench

- Bit-serial sequencer for the existing 1-bit ALU slice (ports src1, src2, less, equal, A_invert, B_invert, cin, operation, bonus_op → result, cout).
- Time-multiplexes one slice over a WIDTH-bit operation, one bit per clock, LSB first.
- Tracks the carry chain between cycles and computes less/equal for compare ops.
- Sits between decode/ALU-control and the register-file writeback in the low-area CPU variant.

---
 rtl/alu_serial_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_alu_serial_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer that drives one 1-bit ALU slice across a WIDTH-bit operand, LSB first.
// Optional build macro ALU_SERIAL_SIGNED_CMP_EN: signed less-than (sign ^ ovf) plus an ovf_o port.
module alu_serial_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ctrl_i,
    input  logic [2:0]       bonus_op_i,
    output logic             slice_src1_o,
    output logic             slice_src2_o,
    output logic             slice_less_o,
    output logic             slice_equal_o,
    output logic             slice_a_inv_o,
    output logic             slice_b_inv_o,
    output logic             slice_cin_o,
    output logic [1:0]       slice_op_o,
    output logic [2:0]       slice_bonus_op_o,
    input  logic             slice_result_i,
    input  logic             slice_cout_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
`ifdef ALU_SERIAL_SIGNED_CMP_EN
    output logic             ovf_o,
`endif
    output logic             busy_o,
    output logic             done_o,
    output logic [1:0]       dbg_state_o
);

    // Handshake: start_i is sampled only in IDLE; operands are latched on that edge.
    // busy_o is high while bits are being processed; done_o pulses for one cycle once
    // result_o/zero_o are updated, and a new start_i is accepted from that cycle on.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       ctrl_q;
    logic [2:0]       bonus_q;
    logic [CNT_W-1:0] idx;
    logic             carry;
    logic             eq;
    logic             sign;
    logic [WIDTH-1:0] res;
    logic             is_cmp;
    logic             last_bit;
    logic             less;
`ifdef ALU_SERIAL_SIGNED_CMP_EN
    logic             ovf;
`endif

    assign is_cmp   = (ctrl_q[1:0] == 2'b11);
    assign last_bit = (idx == LAST_IDX);

`ifdef ALU_SERIAL_SIGNED_CMP_EN
    assign less = sign ^ ovf;
`else
    // Raw MSB of the difference, identical to the combinational ripple ALU.
    assign less = sign;
`endif

    assign busy_o      = (state == RUN) || (state == CMP);
    assign dbg_state_o = state;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        slice_src1_o     = 1'b0;
        slice_src2_o     = 1'b0;
        slice_less_o     = 1'b0;
        slice_equal_o    = 1'b0;
        slice_a_inv_o    = 1'b0;
        slice_b_inv_o    = 1'b0;
        slice_cin_o      = 1'b0;
        slice_op_o       = 2'b00;
        slice_bonus_op_o = 3'b000;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                slice_src1_o = a_q[idx];
                slice_src2_o = b_q[idx];
                slice_cin_o  = carry;
                if (is_cmp) begin
                    // Compare runs the slice as a subtractor to form the difference.
                    slice_a_inv_o = 1'b0;
                    slice_b_inv_o = 1'b1;
                    slice_op_o    = 2'b10;
                end else begin
                    slice_a_inv_o = ctrl_q[3];
                    slice_b_inv_o = ctrl_q[2];
                    slice_op_o    = ctrl_q[1:0];
                end
                if (last_bit) begin
                    state_nxt = is_cmp ? CMP : DONE;
                end
            end
            CMP: begin
                slice_op_o       = 2'b11;
                slice_bonus_op_o = (bonus_q == 3'd6) ? 3'd7 : bonus_q;
                slice_less_o     = less;
                slice_equal_o    = eq;
                state_nxt        = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q      <= '0;
            b_q      <= '0;
            ctrl_q   <= '0;
            bonus_q  <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            eq       <= 1'b0;
            sign     <= 1'b0;
            res      <= '0;
            result_o <= '0;
            zero_o   <= 1'b0;
            cout_o   <= 1'b0;
            done_o   <= 1'b0;
`ifdef ALU_SERIAL_SIGNED_CMP_EN
            ovf      <= 1'b0;
            ovf_o    <= 1'b0;
`endif
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        a_q     <= src1_i;
                        b_q     <= src2_i;
                        ctrl_q  <= ctrl_i;
                        bonus_q <= bonus_op_i;
                        idx     <= '0;
                        carry   <= (ctrl_i[1:0] == 2'b11) ? 1'b1 : ctrl_i[2];
                        eq      <= 1'b1;
                        res     <= '0;
                    end
                end
                RUN: begin
                    res[idx] <= slice_result_i;
                    carry    <= slice_cout_i;
                    if (is_cmp) begin
                        eq <= eq & ~slice_result_i;
                    end
                    if (last_bit) begin
                        cout_o <= slice_cout_i;
                        sign   <= slice_result_i;
`ifdef ALU_SERIAL_SIGNED_CMP_EN
                        // Carry into the MSB differs from carry out on two's-complement overflow.
                        ovf    <= carry ^ slice_cout_i;
`endif
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                CMP: begin
                    res <= {{(WIDTH-1){1'b0}}, slice_result_i};
                end
                DONE: begin
                    result_o <= res;
                    zero_o   <= (res == '0);
                    done_o   <= 1'b1;
`ifdef ALU_SERIAL_SIGNED_CMP_EN
                    ovf_o    <= ovf;
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for alu_serial_ctrl at WIDTH=8 with a behavioural 1-bit ALU slice.
module tb_alu_serial_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] src1 = '0;
  logic [W-1:0] src2 = '0;
  logic [3:0]   ctrl = '0;
  logic [2:0]   bonus = '0;
  logic         s_src1, s_src2, s_less, s_equal, s_ainv, s_binv, s_cin;
  logic [1:0]   s_op;
  logic [2:0]   s_bonus;
  logic         s_result, s_cout;
  logic [W-1:0] result;
  logic         zero, cout, busy, done;
  logic [1:0]   dbg_state;
`ifdef ALU_SERIAL_SIGNED_CMP_EN
  logic         ovf;
`endif

  int checks = 0;
  int failures = 0;

  // Clock / reset
  always #5 clk = ~clk;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .src1_i(src1), .src2_i(src2), .ctrl_i(ctrl), .bonus_op_i(bonus),
    .slice_src1_o(s_src1), .slice_src2_o(s_src2), .slice_less_o(s_less),
    .slice_equal_o(s_equal), .slice_a_inv_o(s_ainv), .slice_b_inv_o(s_binv),
    .slice_cin_o(s_cin), .slice_op_o(s_op), .slice_bonus_op_o(s_bonus),
    .slice_result_i(s_result), .slice_cout_i(s_cout),
    .result_o(result), .zero_o(zero), .cout_o(cout),
`ifdef ALU_SERIAL_SIGNED_CMP_EN
    .ovf_o(ovf),
`endif
    .busy_o(busy), .done_o(done), .dbg_state_o(dbg_state)
  );

  // Behavioural 1-bit ALU slice: 0 and, 1 or, 2 add, 3 compare select.
  logic sa, sb;
  always_comb begin
    sa = s_src1 ^ s_ainv;
    sb = s_src2 ^ s_binv;
    s_cout = (sa & sb) | (sa & s_cin) | (sb & s_cin);
    s_result = 1'b0;
    case (s_op)
      2'd0: s_result = sa & sb;
      2'd1: s_result = sa | sb;
      2'd2: s_result = sa ^ sb ^ s_cin;
      default: begin
        case (s_bonus)
          3'd0: s_result = s_less;
          3'd1: s_result = ~s_less & ~s_equal;
          3'd2: s_result = s_less | s_equal;
          3'd3: s_result = ~s_less;
          3'd4: s_result = s_equal;
          3'd5: s_result = ~s_equal;
          3'd6: s_result = 1'b1;
          default: s_result = ~s_equal;
        endcase
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver: issue one operation and wait for done_o (sampled on negedges).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c,
                        input logic [2:0] bo, output int lat, output logic cin0,
                        output logic busy0, output logic done_after);
    int n;
    @(negedge clk);
    src1 = a; src2 = b; ctrl = c; bonus = bo; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cin0 = s_cin;
    busy0 = busy;
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done) break;
    end
    if (!done) check("timeout", 32'(n), 32'(W + 2));
    lat = n;
    @(negedge clk);
    done_after = done;
    @(posedge clk);
    #1;
  endtask

  int   lat;
  logic cin0, busy0, done_after;
  int   done_cnt;

  initial begin
    // Reset state
    #12;
    check("rst_result", 32'(result), 0);
    check("rst_zero", 32'(zero), 0);
    check("rst_cout", 32'(cout), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_state", 32'(dbg_state), 0);
    check("rst_cin", 32'(s_cin), 0);
    @(negedge clk);
    rst = 1'b0;

    // 5 + 3
    run_op(8'd5, 8'd3, 4'b0010, 3'd0, lat, cin0, busy0, done_after);
    check("add_lat", 32'(lat), 9);
    check("add_busy", 32'(busy0), 1);
    check("add_res", 32'(result), 8);
    check("add_zero", 32'(zero), 0);
    check("add_cout", 32'(cout), 0);
    check("add_pulse", 32'(done_after), 0);

    // 3 - 3
    run_op(8'd3, 8'd3, 4'b0110, 3'd0, lat, cin0, busy0, done_after);
    check("sub_res", 32'(result), 0);
    check("sub_zero", 32'(zero), 1);
    check("sub_cout", 32'(cout), 1);
    check("sub_cin0", 32'(cin0), 1);

    // 0x80 - 1 overflows
    run_op(8'h80, 8'h01, 4'b0110, 3'd0, lat, cin0, busy0, done_after);
    check("subov_res", 32'(result), 32'h7F);
    check("subov_cout", 32'(cout), 1);
`ifdef ALU_SERIAL_SIGNED_CMP_EN
    check("subov_ovf", 32'(ovf), 1);
`endif

    // Logic ops
    run_op(8'hCC, 8'hAA, 4'b0000, 3'd0, lat, cin0, busy0, done_after);
    check("and_res", 32'(result), 32'h88);
    run_op(8'hCC, 8'hAA, 4'b0001, 3'd0, lat, cin0, busy0, done_after);
    check("or_res", 32'(result), 32'hEE);

    // Compares
    run_op(8'hFD, 8'h02, 4'b0011, 3'd0, lat, cin0, busy0, done_after);
    check("slt_lat", 32'(lat), 10);
    check("slt_res", 32'(result), 1);
    check("slt_cin0", 32'(cin0), 1);
    run_op(8'h02, 8'hFD, 4'b0011, 3'd0, lat, cin0, busy0, done_after);
    check("slt_rev", 32'(result), 0);
    run_op(8'h7F, 8'h80, 4'b0011, 3'd0, lat, cin0, busy0, done_after);
`ifdef ALU_SERIAL_SIGNED_CMP_EN
    check("slt_ovf_res", 32'(result), 0);
    check("slt_ovf_flag", 32'(ovf), 1);
`else
    check("slt_raw_res", 32'(result), 1);
`endif
    run_op(8'h55, 8'h55, 4'b0011, 3'd4, lat, cin0, busy0, done_after);
    check("seq_res", 32'(result), 1);
    run_op(8'h55, 8'h55, 4'b0011, 3'd5, lat, cin0, busy0, done_after);
    check("sne_res", 32'(result), 0);
    run_op(8'h55, 8'h55, 4'b0011, 3'd6, lat, cin0, busy0, done_after);
    check("op6_res", 32'(result), 0);

    // start_i while busy is ignored
    @(negedge clk);
    src1 = 8'd5; src2 = 8'd3; ctrl = 4'b0010; bonus = 3'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    src1 = 8'hFF; src2 = 8'hFF; ctrl = 4'b0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("busy_ign_done", 32'(done_cnt), 1);
    check("busy_ign_res", 32'(result), 8);

    // Reset aborts mid-run at idx 4
    @(negedge clk);
    src1 = 8'h12; src2 = 8'h34; ctrl = 4'b0010; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_res", 32'(result), 0);
    check("abort_state", 32'(dbg_state), 0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort_nodone", 32'(done_cnt), 0);

    // Recovery after abort
    run_op(8'h12, 8'h34, 4'b0010, 3'd0, lat, cin0, busy0, done_after);
    check("recover_res", 32'(result), 32'h46);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
